// File: rtl/eeprom32k_reader_if.sv
// eeprom32k_reader_if: request, status and EEPROM bus signals of the reader.
// master drives requests and EEPROM read data; slave is the reader itself.
interface eeprom32k_reader_if;
    logic        start;
    logic        abort;
    logic [12:0] base;
    logic [6:0]  count;
    logic        busy;
    logic [31:0] data;
    logic        data_valid;
    logic        done;
    logic [12:0] a;
    logic [31:0] io_in;
    logic        ce;
    logic        oe;
    logic        we;

    modport master (
        output start, abort, base, count, io_in,
        input  busy, data, data_valid, done, a, ce, oe, we
    );

    modport slave (
        input  start, abort, base, count, io_in,
        output busy, data, data_valid, done, a, ce, oe, we
    );
endinterface

// File: rtl/eeprom32k_reader.sv
// eeprom32k_reader: burst reader for an 8K x 32 parallel EEPROM (read only).
// Optional single-word read cache enabled by defining EEPROM_READ_CACHE_EN.
module eeprom32k_reader #(
    parameter int SETUP_CYCLES  = 1,
    parameter int ACCESS_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst,
    eeprom32k_reader_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    localparam logic [3:0] SETUP_LAST  = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] ACCESS_LAST = 4'(ACCESS_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    logic [3:0] wait_cnt;
    logic [6:0] remaining;
    logic       last_wait;
    logic       req;
    logic       accept;
    logic       capture;
    logic       cache_hit;

    // io_in bit 31 is the EEPROM's bit 0 (MSB), so words keep their value.
    assign last_wait = (wait_cnt == 4'd0);
    assign req       = (state == IDLE) && bus.start && !bus.abort;
    assign accept    = req && (bus.count != 7'd0) && !cache_hit;
    assign capture   = (state == ACCESS) && last_wait && !bus.abort;
    assign bus.we    = 1'b1;

`ifdef EEPROM_READ_CACHE_EN
    logic        cache_valid;
    logic [12:0] cache_tag;
    logic [31:0] cache_data;

    assign cache_hit = cache_valid && (bus.count == 7'd1)
                       && (cache_tag == bus.base);

    // Remember the most recently captured word; abort drops it.
    always_ff @(posedge clk) begin
        if (rst || bus.abort) begin
            cache_valid <= 1'b0;
        end else if (capture) begin
            cache_valid <= 1'b1;
            cache_tag   <= bus.a;
            cache_data  <= bus.io_in;
        end
    end
`else
    assign cache_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic: abort always wins over sequencing.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept) state_next = SETUP;
            end
            SETUP: begin
                if (bus.abort)      state_next = IDLE;
                else if (last_wait) state_next = ACCESS;
            end
            ACCESS: begin
                if (bus.abort) begin
                    state_next = IDLE;
                end else if (last_wait) begin
                    if (remaining == 7'd1) state_next = IDLE;
                    else                   state_next = SETUP;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Bus strobes and busy decode directly from the state.
    always_comb begin
        bus.busy = (state != IDLE);
        bus.ce   = (state == IDLE);
        bus.oe   = (state != ACCESS);
    end

    // Counters, address, captured data and the status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt       <= 4'd0;
            remaining      <= 7'd0;
            bus.a          <= 13'd0;
            bus.data       <= 32'd0;
            bus.data_valid <= 1'b0;
            bus.done       <= 1'b0;
        end else begin
            bus.data_valid <= 1'b0;
            bus.done       <= 1'b0;
            if (accept) begin
                bus.a     <= bus.base;
                remaining <= bus.count;
                wait_cnt  <= SETUP_LAST;
            end else if (req && bus.count == 7'd0) begin
                bus.done <= 1'b1;
`ifdef EEPROM_READ_CACHE_EN
            end else if (req && cache_hit) begin
                bus.data       <= cache_data;
                bus.data_valid <= 1'b1;
                bus.done       <= 1'b1;
`endif
            end else if (state != IDLE && bus.abort) begin
                remaining <= 7'd0;
            end else if (state != IDLE && !last_wait) begin
                wait_cnt <= wait_cnt - 4'd1;
            end else if (state == SETUP) begin
                wait_cnt <= ACCESS_LAST;
            end else if (capture) begin
                bus.data       <= bus.io_in;
                bus.data_valid <= 1'b1;
                remaining      <= remaining - 7'd1;
                wait_cnt       <= SETUP_LAST;
                if (remaining == 7'd1) bus.done <= 1'b1;
                else                   bus.a    <= bus.a + 13'd1;
            end
        end
    end
endmodule

// File: tb/tb_eeprom32k_reader.sv
// tb_eeprom32k_reader: cycle-by-cycle check of the reader against a
// burst-timeline model, with directed scenarios then random traffic.
module tb_eeprom32k_reader;
    localparam int S  = 1;
    localparam int AC = 3;
    localparam int P  = S + AC;
    localparam int TRN = 2048;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;

    eeprom32k_reader_if bus();

    eeprom32k_reader #(
        .SETUP_CYCLES(S),
        .ACCESS_CYCLES(AC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    // Model: a burst is a timeline of k = 1..cnt*P cycles after START.
    bit          m_active = 0;
    int          m_k = 0;
    int          m_base = 0;
    int          m_cnt = 0;
    logic [12:0] m_ahold = '0;
    logic [31:0] m_data = '0;
    bit          m_dv = 0;
    bit          m_done = 0;
    bit          c_valid = 0;
    logic [12:0] c_tag = '0;
    logic [31:0] c_data = '0;

    logic [31:0] tr_ce[TRN];
    logic [31:0] tr_oe[TRN];
    logic [31:0] tr_busy[TRN];
    logic [31:0] tr_a[TRN];
    logic [31:0] tr_data[TRN];
    logic [31:0] tr_dv[TRN];
    logic [31:0] tr_done[TRN];

    function automatic logic [12:0] m_a();
        if (m_active) return 13'((m_base + (m_k - 1) / P) % 8192);
        return m_ahold;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step(input bit r, input bit st, input bit ab,
                        input logic [12:0] b, input logic [6:0] c,
                        input logic [31:0] io);
        logic [12:0] a_now;
        @(negedge clk);
        a_now = m_a();
        chk("busy", 32'(bus.busy), 32'(m_active));
        chk("ce", 32'(bus.ce), 32'(!m_active));
        chk("oe", 32'(bus.oe), 32'(!(m_active && ((m_k - 1) % P) >= S)));
        chk("we", 32'(bus.we), 32'd1);
        chk("a", 32'(bus.a), 32'(a_now));
        chk("data", bus.data, m_data);
        chk("data_valid", 32'(bus.data_valid), 32'(m_dv));
        chk("done", 32'(bus.done), 32'(m_done));
        if (cyc < TRN) begin
            tr_ce[cyc]   = 32'(bus.ce);
            tr_oe[cyc]   = 32'(bus.oe);
            tr_busy[cyc] = 32'(bus.busy);
            tr_a[cyc]    = 32'(bus.a);
            tr_data[cyc] = bus.data;
            tr_dv[cyc]   = 32'(bus.data_valid);
            tr_done[cyc] = 32'(bus.done);
        end
        rst = r;
        bus.start = st;
        bus.abort = ab;
        bus.base = b;
        bus.count = c;
        bus.io_in = io;
        if (r) begin
            m_active = 0; m_ahold = '0; m_data = '0;
            m_dv = 0; m_done = 0; c_valid = 0;
        end else begin
            m_dv = 0;
            m_done = 0;
            if (m_active) begin
                if (ab) begin
                    m_active = 0; m_ahold = a_now; c_valid = 0;
                end else if (m_k % P == 0) begin
                    m_data = io; m_dv = 1;
                    c_valid = 1; c_tag = a_now; c_data = io;
                    if (m_k / P == m_cnt) begin
                        m_active = 0; m_done = 1; m_ahold = a_now;
                    end else begin
                        m_k++;
                    end
                end else begin
                    m_k++;
                end
            end else if (ab) begin
                c_valid = 0;
            end else if (st) begin
                if (c == 0) begin
                    m_done = 1;
`ifdef EEPROM_READ_CACHE_EN
                end else if (c == 1 && c_valid && c_tag == b) begin
                    m_data = c_data; m_dv = 1; m_done = 1;
`endif
                end else begin
                    m_active = 1; m_k = 1; m_base = int'(b); m_cnt = int'(c);
                end
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n, input logic [31:0] io);
        for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0, io);
    endtask

    initial begin
        int t;
        int sdv;
        int sdone;
        int sce;
        rst = 1'b1;
        bus.start = 0; bus.abort = 0;
        bus.base = '0; bus.count = '0; bus.io_in = '0;
        step(1, 0, 0, '0, '0, '0);
        step(1, 0, 0, '0, '0, '0);
        idle(2, '0);

        // Single word from 0x0010.
        t = cyc;
        step(0, 1, 0, 13'h0010, 7'd1, 32'h428A2F98);
        idle(6, 32'h428A2F98);
        chk("d1_ce_t", tr_ce[t], 1);
        for (int i = 1; i <= 4; i++) chk("d1_ce_low", tr_ce[t+i], 0);
        chk("d1_ce_t5", tr_ce[t+5], 1);
        chk("d1_oe_t1", tr_oe[t+1], 1);
        for (int i = 2; i <= 4; i++) chk("d1_oe_low", tr_oe[t+i], 0);
        chk("d1_dv_t4", tr_dv[t+4], 0);
        chk("d1_dv_t5", tr_dv[t+5], 1);
        chk("d1_done_t5", tr_done[t+5], 1);
        chk("d1_data", tr_data[t+5], 32'h428A2F98);

        // Re-read of the same word.
        t = cyc;
        step(0, 1, 0, 13'h0010, 7'd1, 32'h11111111);
        idle(6, 32'h11111111);
        sce = 0;
        for (int i = 0; i <= 6; i++) sce += int'(tr_ce[t+i] == 0);
`ifdef EEPROM_READ_CACHE_EN
        chk("c_dv_t1", tr_dv[t+1], 1);
        chk("c_done_t1", tr_done[t+1], 1);
        chk("c_data", tr_data[t+1], 32'h428A2F98);
        chk("c_ce_never", 32'(sce), 0);
        step(0, 0, 1, '0, '0, '0);
        t = cyc;
        step(0, 1, 0, 13'h0010, 7'd1, 32'h22222222);
        idle(6, 32'h22222222);
        chk("c_abort_ce", tr_ce[t+1], 0);
        chk("c_abort_data", tr_data[t+5], 32'h22222222);
`else
        chk("nc_ce_cycles", 32'(sce), 4);
        chk("nc_dv_t5", tr_dv[t+5], 1);
        chk("nc_data", tr_data[t+5], 32'h11111111);
`endif

        // Three words across the address wrap.
        t = cyc;
        step(0, 1, 0, 13'h1FFE, 7'd3, 32'hA0000000 + 32'(cyc));
        for (int i = 0; i < 15; i++) step(0, 0, 0, '0, '0, 32'hA0000000 + 32'(cyc));
        chk("d2_a0", tr_a[t+1], 32'h1FFE);
        chk("d2_a1", tr_a[t+5], 32'h1FFF);
        chk("d2_a2", tr_a[t+9], 32'h0000);
        chk("d2_dv1", tr_dv[t+5], 1);
        chk("d2_dv2", tr_dv[t+9], 1);
        chk("d2_dv3", tr_dv[t+13], 1);
        chk("d2_done_mid", tr_done[t+9], 0);
        chk("d2_done", tr_done[t+13], 1);
        chk("d2_data3", tr_data[t+13], 32'hA0000000 + 32'(t + 12));

        // Abort in the second word's access phase.
        t = cyc;
        step(0, 1, 0, 13'h0100, 7'd4, 32'h5A5A0001);
        idle(6, 32'h5A5A0002);
        step(0, 0, 1, '0, '0, 32'h5A5A0003);
        idle(7, 32'h5A5A0004);
        sdv = 0; sdone = 0;
        for (int i = 1; i <= 14; i++) begin
            sdv += int'(tr_dv[t+i]);
            sdone += int'(tr_done[t+i]);
        end
        chk("d3_dv_count", 32'(sdv), 1);
        chk("d3_done_count", 32'(sdone), 0);
        chk("d3_busy", tr_busy[t+8], 0);
        chk("d3_ce", tr_ce[t+8], 1);
        chk("d3_oe", tr_oe[t+8], 1);

        // Zero-length request.
        t = cyc;
        step(0, 1, 0, 13'h0200, 7'd0, '0);
        idle(3, '0);
        chk("d0_done", tr_done[t+1], 1);
        chk("d0_dv", tr_dv[t+1], 0);
        chk("d0_ce", tr_ce[t+1], 1);

        // Reset while in access, then a clean read.
        t = cyc;
        step(0, 1, 0, 13'h0333, 7'd2, 32'h77777777);
        idle(2, 32'h77777777);
        step(1, 0, 0, '0, '0, 32'h77777777);
        idle(2, '0);
        chk("d4_a", tr_a[t+4], 0);
        chk("d4_data", tr_data[t+4], 0);
        chk("d4_ce", tr_ce[t+4], 1);
        chk("d4_busy", tr_busy[t+4], 0);
        t = cyc;
        step(0, 1, 0, 13'h0010, 7'd1, 32'h428A2F98);
        idle(6, 32'h428A2F98);
        chk("d4_rd_dv", tr_dv[t+5], 1);
        chk("d4_rd_data", tr_data[t+5], 32'h428A2F98);

        // Random traffic.
        for (int i = 0; i < 5000; i++) begin
            bit          r;
            bit          st;
            bit          ab;
            logic [12:0] b;
            logic [6:0]  c;
            int          sel;
            r  = ($urandom_range(0, 299) == 0);
            st = ($urandom_range(0, 3) == 0);
            ab = ($urandom_range(0, 29) == 0);
            b  = ($urandom_range(0, 2) == 0) ? 13'h0010 : 13'($urandom);
            sel = int'($urandom_range(0, 19));
            if (sel == 0)      c = 7'd0;
            else if (sel == 1) c = 7'($urandom_range(6, 127));
            else               c = 7'($urandom_range(1, 5));
            step(r, st, ab, b, c, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/eeprom32k_reader.md
EEPROM32K_READER -- requirements
Module: eeprom32k_reader

Interface
REQ-001 Parameter SETUP_CYCLES, default 1: cycles with CE low and OE high before each word's OE assertion, range 1..15.
REQ-002 Parameter ACCESS_CYCLES, default 3: cycles OE is held low per word; IO_IN sampled at the clock edge ending the last of these, range 1..15.
REQ-003 CLK  in  1  single clock; all state changes on rising edge.
REQ-004 RST  in  1  reset, synchronous, active-high.
REQ-005 START  in  1  burst request, sampled only in IDLE.
REQ-006 ABORT  in  1  terminate the burst in progress.
REQ-007 BASE  in  13  first word address.
REQ-008 COUNT  in  7  words to read, 1..127; 0 is a no-op.
REQ-009 BUSY  out  1  high in every state except IDLE.
REQ-010 DATA  out  32  last captured word, held until the next capture.
REQ-011 DATA_VALID  out  1  one-cycle pulse per captured word.
REQ-012 DONE  out  1  one-cycle pulse on burst completion.
REQ-013 A  out  13  EEPROM address.
REQ-014 IO_IN  in  32  EEPROM data; bank 1 on bits [0:7], MSB-first bit order [0:31].
REQ-015 CE, OE, WE  out  1 each  active-low EEPROM strobes.

Function
REQ-016 States: IDLE, SETUP, ACCESS; counters: wait counter 4 bits, remaining-word counter 7 bits.
REQ-017 IDLE: CE=1, OE=1, A holds its last value; START=1 with COUNT!=0 and ABORT=0 loads A=BASE and remaining=COUNT, then enters SETUP.
REQ-018 START with COUNT=0 produces a DONE pulse in the next cycle, no bus activity and no DATA_VALID.
REQ-019 SETUP: CE=0, OE=1 for SETUP_CYCLES cycles, then ACCESS.
REQ-020 ACCESS: CE=0, OE=0 for ACCESS_CYCLES cycles; the edge ending the last cycle registers IO_IN into DATA and decrements remaining.
REQ-021 DATA_VALID is high in the cycle after capture; START in cycle t gives the first DATA_VALID in cycle t+1+SETUP_CYCLES+ACCESS_CYCLES.
REQ-022 After a capture with remaining>0, A increments by 1 (8191 wraps to 0) and the block re-enters SETUP with OE=1; CE stays 0.
REQ-023 After the final capture the block enters IDLE; DONE pulses in the same cycle as the final DATA_VALID.
REQ-024 WE is constant 1; the block never issues a write.
REQ-025 START while BUSY is ignored; BASE and COUNT are sampled only on accepted START.
REQ-026 ABORT=1 in SETUP or ACCESS: IDLE next cycle, CE=OE=1, capture in that edge suppressed, no DATA_VALID, no DONE.
REQ-027 ABORT and START together in IDLE: START ignored.

Reset
REQ-028 RST=1 forces IDLE from any state, mid-burst included: CE=1, OE=1, WE=1, A=0, DATA=0, DATA_VALID=0, DONE=0, BUSY=0, counters=0.

Configuration
REQ-029 Macro EEPROM_READ_CACHE_EN present: single-entry cache (13-bit tag, 32-bit data, valid bit) updated on every capture; START with COUNT=1 and BASE equal to a valid tag gives DATA=cached word, DATA_VALID and DONE in the next cycle, CE stays 1, BUSY stays 0.
REQ-030 Cache valid bit cleared by RST and by ABORT.
REQ-031 Macro absent: no cache storage; every START with COUNT!=0 performs bus reads per REQ-017..REQ-023.

Verification
REQ-032 Defaults, BASE=0x0010, COUNT=1, IO_IN=0x428A2F98 -> CE low t+1..t+4, OE low t+2..t+4, DATA=0x428A2F98 with DATA_VALID and DONE at t+5.
REQ-033 BASE=0x1FFE, COUNT=3 -> A sequence 0x1FFE, 0x1FFF, 0x0000; three DATA_VALID pulses 4 cycles apart; DONE with the third.
REQ-034 ABORT during second word's ACCESS of COUNT=4 -> one DATA_VALID only, no DONE, IDLE next cycle, CE=OE=1.
REQ-035 RST in ACCESS -> all outputs per REQ-028 the following cycle; new START then behaves per REQ-032.
REQ-036 With EEPROM_READ_CACHE_EN: read 0x0010, then START BASE=0x0010 COUNT=1 -> DATA_VALID+DONE at t+1, CE never low; same after ABORT -> full bus read.
